// File: rtl/signal_monitor_if.sv
// ---------------------------------------------------------------------------
// signal_monitor_if
//   Lane-control bus between the intersection controller (master) and the
//   conflict monitor (slave).
//
//   lane1Control..lane4Control : 2-bit lane codes from the controller
//                                (00 red, 01 yellow, 10 green, 11 invalid)
//   yellowTime                 : minimum yellow duration in seconds, 0 = off
//   clearFault                 : synchronous fault-clear request
//   laneOut1..laneOut4         : checked lane codes to the car-signal drivers
//   fault                      : sticky fault flag
//   faultCode                  : cause of the first fault (0 = none)
//   faultLane                  : offending lane index, 0..3
// ---------------------------------------------------------------------------
interface signal_monitor_if;
    logic [1:0] lane1Control;
    logic [1:0] lane2Control;
    logic [1:0] lane3Control;
    logic [1:0] lane4Control;
    logic [5:0] yellowTime;
    logic       clearFault;
    logic [1:0] laneOut1;
    logic [1:0] laneOut2;
    logic [1:0] laneOut3;
    logic [1:0] laneOut4;
    logic       fault;
    logic [2:0] faultCode;
    logic [1:0] faultLane;

    modport master (
        output lane1Control, lane2Control, lane3Control, lane4Control,
        output yellowTime, clearFault,
        input  laneOut1, laneOut2, laneOut3, laneOut4,
        input  fault, faultCode, faultLane
    );

    modport slave (
        input  lane1Control, lane2Control, lane3Control, lane4Control,
        input  yellowTime, clearFault,
        output laneOut1, laneOut2, laneOut3, laneOut4,
        output fault, faultCode, faultLane
    );
endinterface

// File: rtl/signal_monitor.sv
// ---------------------------------------------------------------------------
// signal_monitor
//   Independent conflict monitor between the intersection controller and the
//   four car-signal drivers. Checks the lane codes every clock; on the first
//   violation it latches a sticky fault with its cause and forces all lanes
//   to red until a valid clear (clearFault with every lane red).
//
//   clk    : system clock, rising edge
//   resetN : asynchronous, active-low reset
//   bus    : signal_monitor_if.slave (lane codes in, checked codes and
//            fault status out)
// ---------------------------------------------------------------------------
module signal_monitor #(
    parameter int CLK_PER_SEC = 5000,
    parameter int CNT_W       = 19
) (
    input  logic             clk,
    input  logic             resetN,
    signal_monitor_if.slave  bus
);

    localparam logic [0:0] ST_MONITOR = 1'b0;
    localparam logic [0:0] ST_FAULTED = 1'b1;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    localparam logic [1:0] BAD = 2'b11;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_INVALID = 3'd1;
    localparam logic [2:0] FC_AXIS    = 3'd2;
    localparam logic [2:0] FC_TRANS   = 3'd3;
    localparam logic [2:0] FC_SHORT   = 3'd4;
    localparam logic [2:0] FC_PAIR    = 3'd5;

    logic [1:0]       lane_in    [4];
    logic [1:0]       prev_q     [4];
    logic [1:0]       prev_d     [4];
    logic [CNT_W-1:0] ycnt_q     [4];
    logic [CNT_W-1:0] ycnt_d     [4];
    logic [1:0]       lane_out_q [4];
    logic [1:0]       lane_out_d [4];
    logic [0:0]       state_q, state_d;
    logic [2:0]       fault_code_q, fault_code_d;
    logic [1:0]       fault_lane_q, fault_lane_d;

    logic [CNT_W-1:0] yellow_limit;
    logic [2:0]       det_code;
    logic [1:0]       det_lane;
    logic             fault_now;
    logic             clear_ok;

    assign lane_in[0] = bus.lane1Control;
    assign lane_in[1] = bus.lane2Control;
    assign lane_in[2] = bus.lane3Control;
    assign lane_in[3] = bus.lane4Control;

    // Minimum number of consecutive yellow samples before red is allowed.
    assign yellow_limit = CNT_W'(bus.yellowTime) * CNT_W'(CLK_PER_SEC);

    // Violation detection against the previous sample. Each lane scan runs
    // from lane 3 down so the lowest-indexed offender is the one kept.
    always_comb begin
        logic       inv_hit, trans_hit, short_hit, axis_hit;
        logic [1:0] inv_lane, trans_lane, short_lane, axis_lane;
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        inv_hit    = 1'b0;
        trans_hit  = 1'b0;
        short_hit  = 1'b0;
        inv_lane   = 2'd0;
        trans_lane = 2'd0;
        short_lane = 2'd0;
        axis_lane  = 2'd0;
        det_code   = FC_NONE;
        det_lane   = 2'd0;

        for (int i = 3; i >= 0; i--) begin
            if (lane_in[i] == BAD) begin
                inv_hit  = 1'b1;
                inv_lane = 2'(i);
            end
            if ((prev_q[i] == GRN && lane_in[i] == RED) ||
                (prev_q[i] == RED && lane_in[i] == YEL) ||
                (prev_q[i] == YEL && lane_in[i] == GRN)) begin
                trans_hit  = 1'b1;
                trans_lane = 2'(i);
            end
            if (prev_q[i] == YEL && lane_in[i] == RED && ycnt_q[i] < yellow_limit) begin
                short_hit  = 1'b1;
                short_lane = 2'(i);
            end
            if (lane_in[i] != RED) begin
                axis_lane = 2'(i);
            end
        end

        axis_hit = (lane_in[0] != RED || lane_in[1] != RED) &&
                   (lane_in[2] != RED || lane_in[3] != RED);

        if (inv_hit) begin
            det_code = FC_INVALID;
            det_lane = inv_lane;
        end else if (axis_hit) begin
            det_code = FC_AXIS;
            det_lane = axis_lane;
        end else if (trans_hit) begin
            det_code = FC_TRANS;
            det_lane = trans_lane;
        end else if (short_hit) begin
            det_code = FC_SHORT;
            det_lane = short_lane;
        end else if (lane_in[0] != lane_in[1]) begin
            det_code = FC_PAIR;
            det_lane = 2'd0;
        end else if (lane_in[2] != lane_in[3]) begin
            det_code = FC_PAIR;
            det_lane = 2'd2;
        end
    end

    assign fault_now = (state_q == ST_MONITOR) && (det_code != FC_NONE);
    assign clear_ok  = (state_q == ST_FAULTED) && bus.clearFault &&
                       lane_in[0] == RED && lane_in[1] == RED &&
                       lane_in[2] == RED && lane_in[3] == RED;

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        fault_lane_d = fault_lane_q;

        if (fault_now) begin
            state_d      = ST_FAULTED;
            fault_code_d = det_code;
            fault_lane_d = det_lane;
        end else if (clear_ok) begin
            state_d      = ST_MONITOR;
            fault_code_d = FC_NONE;
            fault_lane_d = 2'd0;
        end

        for (int i = 0; i < 4; i++) begin
            prev_d[i] = lane_in[i];

            if (lane_in[i] == YEL && prev_q[i] == YEL)
                ycnt_d[i] = (ycnt_q[i] == '1) ? ycnt_q[i] : ycnt_q[i] + CNT_W'(1);
            else if (lane_in[i] == YEL)
                ycnt_d[i] = CNT_W'(1);
            else
                ycnt_d[i] = '0;

            if (clear_ok)
                ycnt_d[i] = '0;

            // The fault being detected right now also blanks the outputs, so
            // an offending code never reaches the drivers.
            lane_out_d[i] = (state_q == ST_FAULTED || fault_now) ? RED : lane_in[i];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_MONITOR;
            fault_code_q <= FC_NONE;
            fault_lane_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                prev_q[i]     <= RED;
                ycnt_q[i]     <= '0;
                lane_out_q[i] <= RED;
            end
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            fault_lane_q <= fault_lane_d;
            for (int i = 0; i < 4; i++) begin
                prev_q[i]     <= prev_d[i];
                ycnt_q[i]     <= ycnt_d[i];
                lane_out_q[i] <= lane_out_d[i];
            end
        end
    end

    assign bus.laneOut1  = lane_out_q[0];
    assign bus.laneOut2  = lane_out_q[1];
    assign bus.laneOut3  = lane_out_q[2];
    assign bus.laneOut4  = lane_out_q[3];
    assign bus.fault     = (state_q == ST_FAULTED);
    assign bus.faultCode = fault_code_q;
    assign bus.faultLane = fault_lane_q;

endmodule

// File: tb/tb_signal_monitor.sv
// ---------------------------------------------------------------------------
// tb_signal_monitor
//   Directed bench for signal_monitor with CLK_PER_SEC = 2, yellowTime = 3
//   (6-cycle yellow threshold). The stimulus process drives one vector per
//   cycle and queues the hand-written expected status for it; the monitor
//   process pops and compares one entry after each rising edge.
// ---------------------------------------------------------------------------
module tb_signal_monitor;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    signal_monitor_if bus ();

    signal_monitor #(
        .CLK_PER_SEC (2),
        .CNT_W       (19)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct packed {
        int         id;
        logic       fault;
        logic [2:0] code;
        logic [1:0] lane;
        logic [7:0] outs;   // {laneOut4, laneOut3, laneOut2, laneOut1}
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   vec_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] outs_now();
        return {bus.laneOut4, bus.laneOut3, bus.laneOut2, bus.laneOut1};
    endfunction

    // Drive one vector and queue its expected post-edge status. When no
    // fault is expected the drivers must see exactly this vector.
    task automatic step(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d,
                        input logic clr, input logic ef,
                        input logic [2:0] ec, input logic [1:0] el);
        exp_t e;
        @(negedge clk);
        bus.lane1Control = a;
        bus.lane2Control = b;
        bus.lane3Control = c;
        bus.lane4Control = d;
        bus.clearFault   = clr;
        e.id    = vec_id;
        e.fault = ef;
        e.code  = ec;
        e.lane  = el;
        e.outs  = ef ? 8'h00 : {d, c, b, a};
        sb.push_back(e);
        vec_id++;
    endtask

    task automatic hold(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d, input int n);
        for (int k = 0; k < n; k++)
            step(a, b, c, d, 1'b0, 1'b0, 3'd0, 2'd0);
    endtask

    // Monitor: compare one queued expectation just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("v%0d fault", e.id), 32'(bus.fault), 32'(e.fault));
                check($sformatf("v%0d code", e.id), 32'(bus.faultCode), 32'(e.code));
                check($sformatf("v%0d lane", e.id), 32'(bus.faultLane), 32'(e.lane));
                check($sformatf("v%0d outs", e.id), 32'(outs_now()), 32'(e.outs));
            end
        end
    end

    initial begin
        resetN           = 1'b0;
        bus.lane1Control = 2'b00;
        bus.lane2Control = 2'b00;
        bus.lane3Control = 2'b00;
        bus.lane4Control = 2'b00;
        bus.yellowTime   = 6'd3;
        bus.clearFault   = 1'b0;
        #1;
        check("reset fault", 32'(bus.fault), 32'd0);
        check("reset code", 32'(bus.faultCode), 32'd0);
        check("reset lane", 32'(bus.faultLane), 32'd0);
        check("reset outs", 32'(outs_now()), 32'd0);
        #2 resetN = 1'b1;

        // Normal cycle: lanes 1/2 then lanes 3/4, 6-cycle yellows.
        hold(2'b10, 2'b10, 2'b00, 2'b00, 4);
        hold(2'b01, 2'b01, 2'b00, 2'b00, 6);
        hold(2'b00, 2'b00, 2'b10, 2'b10, 4);
        hold(2'b00, 2'b00, 2'b01, 2'b01, 6);
        hold(2'b00, 2'b00, 2'b00, 2'b00, 1);

        // Short yellow: 5 samples then red -> code 4, lane 0; then clear.
        hold(2'b10, 2'b10, 2'b00, 2'b00, 2);
        hold(2'b01, 2'b01, 2'b00, 2'b00, 5);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 3'd4, 2'd0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'd0, 2'd0);

        // Exactly 6 yellow samples is enough; clearFault while clean is a no-op.
        step(2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 3'd0, 2'd0);
        hold(2'b01, 2'b01, 2'b00, 2'b00, 6);
        hold(2'b00, 2'b00, 2'b00, 2'b00, 1);

        // Axis conflict from all-red: lowest non-red lane is 0.
        step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1, 3'd2, 2'd0);
        step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1, 3'd2, 2'd0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'd0, 2'd0);

        // Invalid code beats pair mismatch: lane index 3.
        step(2'b00, 2'b00, 2'b10, 2'b11, 1'b0, 1'b1, 3'd1, 2'd3);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'd0, 2'd0);

        // Illegal green->red on lanes 3/4, ignored clear, valid clear,
        // then a new violation latches its own cause and is not overwritten.
        step(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 3'd0, 2'd0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 3'd3, 2'd2);
        step(2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 3'd3, 2'd2);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'd0, 2'd0);
        step(2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 3'd3, 2'd1);
        step(2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 1'b1, 3'd3, 2'd1);

        // Asynchronous reset between edges while faulted.
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check("async fault", 32'(bus.fault), 32'd0);
        check("async code", 32'(bus.faultCode), 32'd0);
        check("async lane", 32'(bus.faultLane), 32'd0);
        check("async outs", 32'(outs_now()), 32'd0);
        #1 resetN = 1'b1;

        // History discarded: red->green start is clean.
        hold(2'b10, 2'b10, 2'b00, 2'b00, 2);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 4 && sb.size() != 0; k++)
            @(posedge clk);
        #2;
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signal_monitor.md
# signal_monitor

Independent conflict monitor that sits on the lane-control bus between the intersection controller and the four car-signal drivers. It samples the four 2-bit lane codes each clock and checks them against the legal signal rules: valid codes, paired lanes, no cross-axis conflict, legal colour order and minimum yellow time. On the first violation it latches a sticky fault, records the cause, and forces every lane to red. This makes it the receiving, checking end of the controller's output interface.

## Interface
- CLK_PER_SEC, 5000: clock cycles per second of signal time.
- CNT_W, 19: yellow-hold counter width; must hold 63*CLK_PER_SEC.
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- lane1Control..lane4Control  input  2 each  lane codes from the controller: 00 red, 01 yellow, 10 green, 11 invalid.
- yellowTime  input  6  minimum yellow duration in seconds; 0 disables the short-yellow check.
- clearFault  input  1  synchronous fault-clear request.
- laneOut1..laneOut4  output  2 each  checked lane codes to the car-signal drivers.
- fault  output  1  sticky fault flag.
- faultCode  output  3  cause of the first fault: 0 none, 1 invalid code, 2 axis conflict, 3 illegal transition, 4 short yellow, 5 pair mismatch.
- faultLane  output  2  index of the offending lane: 0..3 for lane1..lane4.

## Operation
- **Per-lane state:** each lane keeps a previous-code register `prev` and a yellow-hold counter `ycnt`.
- **Checks run at every rising edge while `fault` = 0.** Each check compares the current inputs against `prev`.
  1. Any lane = 11 -> code 1.
  2. Any of lanes 1/2 non-red while any of lanes 3/4 is non-red -> code 2.
  3. An illegal transition from `prev` -> code 3. Legal transitions are hold, red->green, green->yellow and yellow->red. All others are illegal: green->red, red->yellow, yellow->green.
  4. yellow->red while `ycnt` < yellowTime*CLK_PER_SEC -> code 4. The product is computed at CNT_W bits.
  5. lane1 != lane2, or lane3 != lane4 -> code 5.
- **Priority:** when several checks fire together, the lowest code wins.
- **faultLane rule:** the lowest-indexed lane violating the winning check.
  - Code 2: the lowest non-red lane.
  - Code 5: lane 0 for the 1/2 pair, lane 2 for the 3/4 pair.
- **Yellow-hold counter:**
  - Input yellow and `prev` yellow: `ycnt`+1, saturating at all-ones.
  - Input yellow and `prev` not yellow: `ycnt` = 1.
  - Otherwise `ycnt` = 0.
- **`prev` tracking:** `prev` loads the current inputs every cycle, including while faulted.
- **Fault latching:** on detection, set `fault` = 1 and latch `faultCode` and `faultLane`. Later violations never overwrite the recorded cause.
- **laneOutN register:** loads 00 if `fault` is already set or a fault is detected at this edge; otherwise it loads laneNControl.
- **Clearing a fault:**
  - If `fault` = 1, clearFault = 1 and all four inputs = 00 at an edge: clear `fault`, `faultCode` and `faultLane` to 0 and zero all `ycnt`. Checks resume at the next edge.
  - clearFault while any input is non-red is ignored.
  - clearFault while `fault` = 0 has no effect.
- **State summary:** two-state machine, MONITOR <-> FAULTED. MONITOR -> FAULTED on any check. FAULTED -> MONITOR only via a valid clear.

## Timing
- **Reset values:** `fault` = 0, `faultCode` = 0, `faultLane` = 0, laneOut1..4 = 00, every `prev` = 00 (red), every `ycnt` = 0.
- **Reset behaviour:** asserting resetN low forces these values immediately, without waiting for a clock edge. Reset mid-fault or mid-yellow discards all history.
- **Output latency:** laneOutN follows its input with 1 cycle latency.
- **Fault latency:** `fault`, `faultCode` and `faultLane` become valid 1 cycle after the offending input is presented. laneOut goes to all-red in that same cycle, so a bad code never reaches the drivers.
- **Short-yellow threshold:** with yellowTime = T, yellow must be sampled on at least T*CLK_PER_SEC consecutive edges before the red sample arrives.
- **Clear latency:** a valid clear drops `fault` 1 cycle after the clear edge. laneOut resumes following inputs from that same edge.

## Test plan
All scenarios use CLK_PER_SEC = 2 and yellowTime = 3, so the threshold is 6 cycles.
- **Normal cycle:** from reset, lanes 1/2 = 10 for 4 cycles, 01 for 6 cycles, then 00 while lanes 3/4 step 10/01/00 the same way -> `fault` stays 0 and each laneOutN equals its input delayed 1 cycle.
- **Short yellow:** lanes 1/2 held 01 for 5 cycles, then 00 -> next cycle `fault` = 1, `faultCode` = 4, `faultLane` = 0, all laneOut = 00. Holding yellow for 6 cycles instead -> no fault.
- **Axis conflict:** from all-red, all four lanes driven to 10 -> `faultCode` = 2, `faultLane` = 0, laneOut = 00.
- **Invalid code with mismatch:** lane3 = 10, lane4 = 11, lanes 1/2 = 00 -> `faultCode` = 1 (beats 5), `faultLane` = 3.
- **Illegal transition then clear:**
  - Lanes 3/4 go 10 -> 00 directly -> `faultCode` = 3, `faultLane` = 2.
  - clearFault with lane1 = 10 -> ignored.
  - clearFault with all lanes 00 -> `fault` = 0 next cycle.
  - A further violation after the clear -> latches its own new code.
- **Asynchronous reset:** while faulted, pulse resetN low between clock edges -> all outputs go to 0 immediately. After release, a red->green start produces no fault.
